// File: rtl/hazard_br_ctrl.sv
// hazard_br_ctrl
// Stall/flush controller for the non-forwarding 5-stage RV32I pipeline.
// A per-register in-flight counter scoreboard detects RAW hazards in ID and
// stalls PC + IF/ID. A small EX-stage register keeps branch control so the
// comparator outcome can be resolved here, producing the PC redirect and the
// IF/ID and ID/EX flushes.
//
// Optional build macro: HAZARD_BR_STATS_EN
//   When defined, adds 32-bit wrapping counters for resolved branches/jumps
//   (o_br_cnt), redirects (o_taken_cnt) and stall cycles (o_stall_cnt).
module hazard_br_ctrl #(
   parameter int CNT_W = 2,
   parameter int NREG  = 32
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_id_valid,
   input  logic [4:0]  i_id_rs1_addr,
   input  logic [4:0]  i_id_rs2_addr,
   input  logic        i_id_rs1_used,
   input  logic        i_id_rs2_used,
   input  logic [4:0]  i_id_rd_addr,
   input  logic        i_id_rd_wren,
   input  logic        i_id_is_br,
   input  logic        i_id_is_jmp,
   input  logic [2:0]  i_id_funct3,
   input  logic        i_br_less,
   input  logic        i_br_equal,
   input  logic [4:0]  i_wb_rd_addr,
   input  logic        i_wb_rd_wren,
   output logic        o_br_unsigned,
   output logic        o_pc_sel,
   output logic        o_stall,
   output logic        o_flush_id,
   output logic        o_flush_ex
`ifdef HAZARD_BR_STATS_EN
   ,
   output logic [31:0] o_br_cnt,
   output logic [31:0] o_taken_cnt,
   output logic [31:0] o_stall_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_STALL = 1'b1
   } state_t;

   // Scoreboard: number of issued-but-not-written-back writers per register
   logic [CNT_W-1:0] r_cnt [NREG];
   logic [NREG-1:0]  w_inc;
   logic [NREG-1:0]  w_dec;

   // EX-stage branch control
   logic             r_ex_valid;
   logic             r_ex_is_br;
   logic             r_ex_is_jmp;
   logic [2:0]       r_ex_funct3;

   // Stall observability FSM
   state_t           r_state;
   state_t           w_state_nxt;

   logic [CNT_W-1:0] w_rs1_cnt;
   logic [CNT_W-1:0] w_rs2_cnt;
   logic             w_rs1_wb_hit;
   logic             w_rs2_wb_hit;
   logic             w_rs1_pend;
   logic             w_rs2_pend;
   logic             w_hazard;
   logic             w_cond;
   logic             w_taken;
   logic             w_redirect;
   logic             w_stall;
   logic             w_issue;

   // Saturating up/down step; simultaneous inc and dec cancel out.
   function automatic logic [CNT_W-1:0] sat_step(
      input logic [CNT_W-1:0] cnt,
      input logic             inc,
      input logic             dec
   );
      logic [CNT_W-1:0] res;
      res = cnt;
      if (inc && !dec && (cnt != CNT_MAX)) begin
         res = cnt + CNT_ONE;
      end else if (dec && !inc && (cnt != CNT_ZERO)) begin
         res = cnt - CNT_ONE;
      end
      return res;
   endfunction

   // A source is pending when some writer is still ahead of it, except that the
   // write-through register file lets a lone writer in WB satisfy it this cycle.
   function automatic logic src_pending(
      input logic             used,
      input logic [4:0]       addr,
      input logic [CNT_W-1:0] cnt,
      input logic             wb_hit
   );
      return used && (addr != 5'd0) && (cnt != CNT_ZERO) &&
             !(wb_hit && (cnt == CNT_ONE));
   endfunction

   // Hazard detection on the two ID source operands.
   always_comb begin
      w_rs1_cnt    = r_cnt[i_id_rs1_addr];
      w_rs2_cnt    = r_cnt[i_id_rs2_addr];
      w_rs1_wb_hit = i_wb_rd_wren && (i_wb_rd_addr == i_id_rs1_addr);
      w_rs2_wb_hit = i_wb_rd_wren && (i_wb_rd_addr == i_id_rs2_addr);
      w_rs1_pend   = src_pending(i_id_rs1_used, i_id_rs1_addr, w_rs1_cnt, w_rs1_wb_hit);
      w_rs2_pend   = src_pending(i_id_rs2_used, i_id_rs2_addr, w_rs2_cnt, w_rs2_wb_hit);
      w_hazard     = w_rs1_pend | w_rs2_pend;
   end

   // Branch/jump resolution for the instruction held in EX.
   always_comb begin
      w_cond = 1'b0;
      case (r_ex_funct3)
         3'b000:         w_cond = i_br_equal;
         3'b001:         w_cond = ~i_br_equal;
         3'b100, 3'b110: w_cond = i_br_less;
         3'b101, 3'b111: w_cond = ~i_br_less;
         default:        w_cond = 1'b0;
      endcase
      w_taken = r_ex_valid & (r_ex_is_jmp | (r_ex_is_br & w_cond));
   end

   // Output decode: a redirect flushes ID, so it overrides both stall and issue.
   always_comb begin
      w_redirect = w_taken;
      w_stall    = i_id_valid & w_hazard & ~w_redirect;
      w_issue    = i_id_valid & ~w_stall & ~w_redirect;
   end

   // Next-state: STALL while ID is being held, back to RUN once it moves on.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:   if (w_stall)  w_state_nxt = ST_STALL;
         ST_STALL: if (!w_stall) w_state_nxt = ST_RUN;
         default:  w_state_nxt = ST_RUN;
      endcase
   end

   // State register for the stall FSM.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Per-register increment on issue and decrement on writeback; x0 excluded.
   always_comb begin
      w_inc = '0;
      w_dec = '0;
      if (w_issue && i_id_rd_wren && (i_id_rd_addr != 5'd0)) begin
         w_inc[i_id_rd_addr] = 1'b1;
      end
      if (i_wb_rd_wren && (i_wb_rd_addr != 5'd0)) begin
         w_dec[i_wb_rd_addr] = 1'b1;
      end
   end

   // Scoreboard counter update.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            r_cnt[r] <= CNT_ZERO;
         end
      end else begin
         for (int r = 0; r < NREG; r++) begin
            r_cnt[r] <= sat_step(r_cnt[r], w_inc[r], w_dec[r]);
         end
      end
   end

   // EX branch-control register; a non-issuing cycle leaves a bubble.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ex_valid  <= 1'b0;
         r_ex_is_br  <= 1'b0;
         r_ex_is_jmp <= 1'b0;
         r_ex_funct3 <= 3'b000;
      end else begin
         r_ex_valid <= w_issue;
         if (w_issue) begin
            r_ex_is_br  <= i_id_is_br;
            r_ex_is_jmp <= i_id_is_jmp;
            r_ex_funct3 <= i_id_funct3;
         end
      end
   end

   // The comparator sees the unsigned select straight from the EX register,
   // so it is already configured when the branch arrives in EX.
   assign o_br_unsigned = r_ex_funct3[1];
   assign o_pc_sel      = w_redirect;
   assign o_flush_id    = w_redirect;
   assign o_flush_ex    = w_redirect;
   assign o_stall       = w_stall;

`ifdef HAZARD_BR_STATS_EN
   logic [31:0] r_br_cnt;
   logic [31:0] r_taken_cnt;
   logic [31:0] r_stall_cnt;

   // Event counters; they wrap naturally at 2^32.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_br_cnt    <= 32'd0;
         r_taken_cnt <= 32'd0;
         r_stall_cnt <= 32'd0;
      end else begin
         if (r_ex_valid && (r_ex_is_br || r_ex_is_jmp)) begin
            r_br_cnt <= r_br_cnt + 32'd1;
         end
         if (w_redirect) begin
            r_taken_cnt <= r_taken_cnt + 32'd1;
         end
         if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign o_br_cnt    = r_br_cnt;
   assign o_taken_cnt = r_taken_cnt;
   assign o_stall_cnt = r_stall_cnt;
`endif

`ifndef SYNTHESIS
   // Simulation checks: counters never over/underflow, and a held ID
   // instruction leaves the STALL state only by issuing or being flushed.
   always @(posedge i_clk) begin
      if (i_rst_n) begin
         for (int r = 0; r < NREG; r++) begin
            if (w_inc[r] && !w_dec[r]) begin
               assert (r_cnt[r] != CNT_MAX)
                  else $error("hazard_br_ctrl: in-flight counter overflow on x%0d", r);
            end
            if (w_dec[r] && !w_inc[r]) begin
               assert (r_cnt[r] != CNT_ZERO)
                  else $error("hazard_br_ctrl: in-flight counter underflow on x%0d", r);
            end
         end
         if ((r_state == ST_STALL) && !w_stall && i_id_valid) begin
            assert (w_issue || w_redirect)
               else $error("hazard_br_ctrl: stall released without issue or flush");
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_br_ctrl.sv
// tb_hazard_br_ctrl
// Drives hazard_br_ctrl as the ID/EX/MEM/WB pipeline around it would: the
// bench owns the in-flight instruction slots, feeds WB from its own MEM->WB
// shift, and predicts stall/redirect from the hazard and branch rules.
// Expectations are queued per cycle and checked by an independent monitor.
`timescale 1ns/1ps
module tb_hazard_br_ctrl;

   typedef struct {
      bit       v;
      bit [4:0] rs1;
      bit       u1;
      bit [4:0] rs2;
      bit       u2;
      bit [4:0] rd;
      bit       wren;
      bit       br;
      bit       jmp;
      bit [2:0] f3;
   } instr_t;

   typedef struct {
      bit stall;
      bit pc_sel;
      bit flush_id;
      bit flush_ex;
      bit uns;
      bit chk_uns;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs1_addr;
   logic [4:0]  id_rs2_addr;
   logic        id_rs1_used;
   logic        id_rs2_used;
   logic [4:0]  id_rd_addr;
   logic        id_rd_wren;
   logic        id_is_br;
   logic        id_is_jmp;
   logic [2:0]  id_funct3;
   logic        br_less;
   logic        br_equal;
   logic [4:0]  wb_rd_addr;
   logic        wb_rd_wren;
   logic        br_unsigned;
   logic        pc_sel;
   logic        stall;
   logic        flush_id;
   logic        flush_ex;
`ifdef HAZARD_BR_STATS_EN
   logic [31:0] br_cnt;
   logic [31:0] taken_cnt;
   logic [31:0] stall_cnt;
`endif

   hazard_br_ctrl #(.CNT_W(2), .NREG(32)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_id_valid    (id_valid),
      .i_id_rs1_addr (id_rs1_addr),
      .i_id_rs2_addr (id_rs2_addr),
      .i_id_rs1_used (id_rs1_used),
      .i_id_rs2_used (id_rs2_used),
      .i_id_rd_addr  (id_rd_addr),
      .i_id_rd_wren  (id_rd_wren),
      .i_id_is_br    (id_is_br),
      .i_id_is_jmp   (id_is_jmp),
      .i_id_funct3   (id_funct3),
      .i_br_less     (br_less),
      .i_br_equal    (br_equal),
      .i_wb_rd_addr  (wb_rd_addr),
      .i_wb_rd_wren  (wb_rd_wren),
      .o_br_unsigned (br_unsigned),
      .o_pc_sel      (pc_sel),
      .o_stall       (stall),
      .o_flush_id    (flush_id),
      .o_flush_ex    (flush_ex)
`ifdef HAZARD_BR_STATS_EN
      ,
      .o_br_cnt      (br_cnt),
      .o_taken_cnt   (taken_cnt),
      .o_stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference model state: one slot per pipeline stage past ID.
   instr_t      id_cur;
   instr_t      ex_s;
   instr_t      mem_s;
   instr_t      wb_s;
   bit          last_issue;
   bit          last_stall;
   bit          less_v;
   bit          eq_v;
   instr_t      dq[$];
   exp_t        expq[$];
   int          n_total;
   int          n_pass;
   int unsigned m_br;
   int unsigned m_tk;
   int unsigned m_st;

   function automatic instr_t none();
      instr_t t;
      t.v = 1'b0; t.rs1 = 5'd0; t.u1 = 1'b0; t.rs2 = 5'd0; t.u2 = 1'b0;
      t.rd = 5'd0; t.wren = 1'b0; t.br = 1'b0; t.jmp = 1'b0; t.f3 = 3'd0;
      return t;
   endfunction

   function automatic instr_t mk(int rs1, int rs2, int rd, int wren, int br, int jmp, int f3);
      instr_t t;
      t.v    = 1'b1;
      t.rs1  = 5'(rs1);
      t.u1   = 1'b1;
      t.rs2  = 5'(rs2);
      t.u2   = 1'b1;
      t.rd   = 5'(rd);
      t.wren = (wren != 0);
      t.br   = (br != 0);
      t.jmp  = (jmp != 0);
      t.f3   = 3'(f3);
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      int     k;
      k      = int'($urandom_range(0, 99));
      t.v    = ($urandom_range(0, 9) != 0);
      t.rs1  = 5'($urandom_range(0, 6));
      t.u1   = 1'($urandom_range(0, 1));
      t.rs2  = 5'($urandom_range(0, 6));
      t.u2   = 1'($urandom_range(0, 1));
      t.rd   = 5'($urandom_range(0, 6));
      t.br   = (k < 20);
      t.jmp  = (k >= 20) && (k < 28);
      t.wren = t.br ? 1'b0 : ($urandom_range(0, 9) < 7);
      t.f3   = 3'($urandom_range(0, 7));
      return t;
   endfunction

   // A register is unavailable while a writer sits in EX or MEM; a writer in
   // WB is readable this cycle through the write-through register file.
   function automatic bit pend(bit [4:0] a);
      return (a != 5'd0) &&
             ((ex_s.v  && ex_s.wren  && (ex_s.rd  == a)) ||
              (mem_s.v && mem_s.wren && (mem_s.rd == a)));
   endfunction

   function automatic bit br_cond(bit [2:0] f3, bit less, bit eq);
      case (f3)
         3'b000:         return eq;
         3'b001:         return !eq;
         3'b100, 3'b110: return less;
         3'b101, 3'b111: return !less;
         default:        return 1'b0;
      endcase
   endfunction

   task automatic drive();
      id_valid    = id_cur.v;
      id_rs1_addr = id_cur.rs1;
      id_rs2_addr = id_cur.rs2;
      id_rs1_used = id_cur.u1;
      id_rs2_used = id_cur.u2;
      id_rd_addr  = id_cur.rd;
      id_rd_wren  = id_cur.wren;
      id_is_br    = id_cur.br;
      id_is_jmp   = id_cur.jmp;
      id_funct3   = id_cur.f3;
      br_less     = less_v;
      br_equal    = eq_v;
      wb_rd_addr  = wb_s.rd;
      wb_rd_wren  = wb_s.v && wb_s.wren;
   endtask

   // One clock of stimulus plus the model's prediction for that clock.
   // rst_lvl = 1 asserts (or holds) reset partway into the cycle.
   task automatic cycle(input bit rnd, input bit rst_lvl);
      exp_t e;
      bit   tk;
      bit   hz;
      bit   stl;
      bit   iss;
      @(posedge clk);
      #1;
      if (!rst_lvl) rst_n = 1'b1;
      wb_s  = mem_s;
      mem_s = ex_s;
      ex_s  = last_issue ? id_cur : none();
      if (!last_stall) begin
         if (dq.size() > 0)  id_cur = dq.pop_front();
         else if (rnd)       id_cur = rand_instr();
         else                id_cur = none();
      end
      if (rnd) begin
         less_v = 1'($urandom_range(0, 1));
         eq_v   = 1'($urandom_range(0, 1));
      end
      drive();
      if (rst_lvl) begin
         #1;
         rst_n      = 1'b0;
         ex_s       = none();
         mem_s      = none();
         wb_s       = none();
         last_issue = 1'b0;
         last_stall = 1'b0;
         m_br       = 0;
         m_tk       = 0;
         m_st       = 0;
         e.stall = 1'b0; e.pc_sel = 1'b0; e.flush_id = 1'b0; e.flush_ex = 1'b0;
         e.uns = 1'b0; e.chk_uns = 1'b1;
         expq.push_back(e);
         return;
      end
      tk  = ex_s.v && (ex_s.jmp || (ex_s.br && br_cond(ex_s.f3, less_v, eq_v)));
      hz  = (id_cur.u1 && pend(id_cur.rs1)) || (id_cur.u2 && pend(id_cur.rs2));
      stl = id_cur.v && hz && !tk;
      iss = id_cur.v && !stl && !tk;
      e.stall    = stl;
      e.pc_sel   = tk;
      e.flush_id = tk;
      e.flush_ex = tk;
      e.uns      = ex_s.f3[1];
      e.chk_uns  = ex_s.v;
      expq.push_back(e);
      if (ex_s.v && (ex_s.br || ex_s.jmp)) m_br++;
      if (tk)  m_tk++;
      if (stl) m_st++;
      last_issue = iss;
      last_stall = stl;
   endtask

   task automatic chk(input string nm, input logic got, input bit want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s t=%0t got=%0b expected=%0b", nm, $time, got, want);
   endtask

   task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, got, want);
   endtask

   // Monitor: every cycle the DUT presents its control outputs; compare them
   // against the oldest queued prediction.
   always @(negedge clk) begin
      exp_t e;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk("stall",    stall,    e.stall);
         chk("pc_sel",   pc_sel,   e.pc_sel);
         chk("flush_id", flush_id, e.flush_id);
         chk("flush_ex", flush_ex, e.flush_ex);
         if (e.chk_uns) chk("br_unsigned", br_unsigned, e.uns);
      end
   end

   initial begin
      n_total    = 0;
      n_pass     = 0;
      rst_n      = 1'b0;
      id_cur     = none();
      ex_s       = none();
      mem_s      = none();
      wb_s       = none();
      last_issue = 1'b0;
      last_stall = 1'b0;
      less_v     = 1'b0;
      eq_v       = 1'b0;
      m_br       = 0;
      m_tk       = 0;
      m_st       = 0;
      drive();

      repeat (3) cycle(1'b0, 1'b1);

      // Directed program, comparator flags fixed at less=1, equal=0.
      less_v = 1'b1;
      eq_v   = 1'b0;
      dq.push_back(mk(1, 2, 5, 1, 0, 0, 0));   // add x5
      dq.push_back(mk(5, 1, 6, 1, 0, 0, 0));   // sub x6,x5,x1 : RAW on x5
      dq.push_back(mk(1, 1, 0, 1, 0, 0, 0));   // addi x0
      dq.push_back(mk(0, 0, 8, 1, 0, 0, 0));   // reads x0 : never stalls
      dq.push_back(mk(1, 2, 0, 0, 1, 0, 6));   // bltu : taken
      dq.push_back(mk(8, 8, 7, 1, 0, 0, 0));   // hazard on x8, flushed by bltu
      dq.push_back(mk(1, 2, 0, 0, 1, 0, 0));   // beq : not taken (equal=0)
      dq.push_back(mk(1, 2, 0, 0, 1, 0, 2));   // funct3=010 : never taken
      dq.push_back(mk(7, 1, 3, 0, 0, 0, 0));   // x7 was never counted
      dq.push_back(mk(1, 2, 7, 1, 0, 0, 0));   // add x7
      dq.push_back(mk(1, 2, 0, 0, 0, 0, 0));
      dq.push_back(mk(1, 2, 0, 0, 0, 0, 0));
      dq.push_back(mk(1, 2, 7, 1, 0, 0, 0));   // add x7 issues while first is in WB
      dq.push_back(mk(7, 7, 4, 1, 0, 0, 0));   // reader waits for second x7
      dq.push_back(mk(1, 2, 1, 1, 0, 1, 3));   // jal : always taken
      repeat (30) cycle(1'b0, 1'b0);

      repeat (3000) cycle(1'b1, 1'b0);

      // Drain, then assert reset while a RAW stall is active.
      repeat (6) cycle(1'b0, 1'b0);
      dq.push_back(mk(1, 2, 9, 1, 0, 0, 0));   // add x9
      dq.push_back(mk(9, 1, 10, 1, 0, 0, 0));  // reader of x9 : stalls
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      dq.push_back(mk(9, 9, 11, 1, 0, 0, 0));  // x9 count cleared : no stall
      cycle(1'b0, 1'b0);

      repeat (500) cycle(1'b1, 1'b0);

      @(posedge clk);
      #1;
`ifdef HAZARD_BR_STATS_EN
      chk32("br_cnt",    br_cnt,    m_br);
      chk32("taken_cnt", taken_cnt, m_tk);
      chk32("stall_cnt", stall_cnt, m_st);
`endif
      @(negedge clk);
      #1;
      chk32("expect_queue_drained", 32'(expq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
